// File: rtl/logic_op_pipe_if.sv
// ---------------------------------------------------------------------------
// logic_op_pipe_if
//   Handshake bundle for logic_op_pipe: an upstream operand push channel and a
//   downstream result channel, plus FIFO occupancy.
//
//   Signals:
//     in_valid  / in_ready   upstream valid/ready
//     in1, in2               WIDTH-bit operands
//     op                     2-bit function select (00 AND, 01 OR, 10 XOR, 11 NOR)
//     out_valid / out_ready  downstream valid/ready
//     out                    registered result
//     out_zero               registered flag, out == 0
//     count                  FIFO occupancy, 0..DEPTH
//     out_parity             XOR-reduce of out (only with LOGIC_OP_PIPE_PARITY_EN)
//
//   Modports:
//     master  producer/consumer side (drives operands and out_ready)
//     slave   the pipe itself
//
//   Optional feature macro: LOGIC_OP_PIPE_PARITY_EN
// ---------------------------------------------------------------------------
interface logic_op_pipe_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_zero;
    logic [CW-1:0]    count;
`ifdef LOGIC_OP_PIPE_PARITY_EN
    logic             out_parity;
`endif

    modport master (
        output in_valid, in1, in2, op, out_ready,
        input  in_ready, out_valid, out, out_zero, count
`ifdef LOGIC_OP_PIPE_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  in_valid, in1, in2, op, out_ready,
        output in_ready, out_valid, out, out_zero, count
`ifdef LOGIC_OP_PIPE_PARITY_EN
        , output out_parity
`endif
    );
endinterface

// File: rtl/logic_op_pipe.sv
// ---------------------------------------------------------------------------
// logic_op_pipe
//   Buffered, handshaked bitwise logic stage. Operand pairs plus an op code are
//   queued in a small FIFO; the head entry is evaluated and captured in an
//   output register that is drained under valid/ready flow control.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    logic_op_pipe_if.slave (operand push, result pop, occupancy)
//
//   Parameters:
//     WIDTH  operand/result width
//     DEPTH  FIFO entries, 2 or 4
//
//   Optional feature macro: LOGIC_OP_PIPE_PARITY_EN adds bus.out_parity, the
//   XOR-reduce of the registered result.
// ---------------------------------------------------------------------------
module logic_op_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    logic_op_pipe_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    // FIFO storage
    logic [WIDTH-1:0] r_mem_in1 [DEPTH];
    logic [WIDTH-1:0] r_mem_in2 [DEPTH];
    op_e              r_mem_op  [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Output register
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_out_zero;
`ifdef LOGIC_OP_PIPE_PARITY_EN
    logic             r_out_parity;
`endif

    logic             w_in_ready;
    logic             w_push;
    logic             w_load;
    logic [WIDTH-1:0] w_result;

    // No pass-through when full: a same-cycle pop does not open in_ready.
    assign w_in_ready = !reset && (r_count != FULL);
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_load     = (r_count != '0) && (!r_out_valid || bus.out_ready);

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_result = '0;
        case (r_mem_op[r_rd_ptr])
            OP_AND:  w_result =   r_mem_in1[r_rd_ptr] & r_mem_in2[r_rd_ptr];
            OP_OR:   w_result =   r_mem_in1[r_rd_ptr] | r_mem_in2[r_rd_ptr];
            OP_XOR:  w_result =   r_mem_in1[r_rd_ptr] ^ r_mem_in2[r_rd_ptr];
            OP_NOR:  w_result = ~(r_mem_in1[r_rd_ptr] | r_mem_in2[r_rd_ptr]);
            default: w_result = '0;
        endcase
    end

    // NOTE: the storage array has no reset; entries are only ever read once
    // count says they were written, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_in1[r_wr_ptr] <= bus.in1;
            r_mem_in2[r_wr_ptr] <= bus.in2;
            r_mem_op[r_wr_ptr]  <= op_e'(bus.op);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out        <= '0;
            r_out_zero   <= 1'b0;
`ifdef LOGIC_OP_PIPE_PARITY_EN
            r_out_parity <= 1'b0;
`endif
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_out        <= w_result;
            r_out_zero   <= (w_result == '0);
`ifdef LOGIC_OP_PIPE_PARITY_EN
            r_out_parity <= ^w_result;
`endif
        end else if (bus.out_ready) begin
            // Consumed with nothing to replace it; out keeps its last value.
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.out_zero  = r_out_zero;
    assign bus.count     = r_count;
`ifdef LOGIC_OP_PIPE_PARITY_EN
    assign bus.out_parity = r_out_parity;
`endif
endmodule

// File: tb/tb_logic_op_pipe.sv
module tb_logic_op_pipe;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    logic_op_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    logic_op_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        bus.in_valid = v;
        bus.in1      = a;
        bus.in2      = b;
        bus.op       = o;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] o,
                              input logic z, input int c);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        if (v) begin
            check({tag, ".out"},  bus.out, o);
            check({tag, ".zero"}, 32'(bus.out_zero), 32'(z));
        end
        check({tag, ".count"}, 32'(bus.count), 32'(c));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        step();
        check("rst.in_ready",  32'(bus.in_ready), 32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.count",     32'(bus.count), 32'd0);
        check("rst.out",       bus.out, 32'h0);
        check("rst.zero",      32'(bus.out_zero), 32'd0);
        reset = 1'b0;
        step();
        check("idle.in_ready", 32'(bus.in_ready), 32'd1);

        // Single OR with one-edge latency
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0000A5A5, 32'h00005A5A, 2'b01);
        step();
        drive(1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b11);
        expect_out("single.k", 1'b0, 32'h0, 1'b0, 1);
        step();
        expect_out("single.k1", 1'b1, 32'h0000FFFF, 1'b0, 0);
        step();
        expect_out("single.k2", 1'b0, 32'h0, 1'b0, 0);
        check("single.hold_out", bus.out, 32'h0000FFFF);

        // Back-to-back AND / XOR / NOR on the same pair
        drive(1'b1, 32'h0000A5A5, 32'h00005A5A, 2'b00);
        step();
        drive(1'b1, 32'h0000A5A5, 32'h00005A5A, 2'b10);
        step();
        expect_out("b2b.and", 1'b1, 32'h00000000, 1'b1, 1);
        drive(1'b1, 32'h0000A5A5, 32'h00005A5A, 2'b11);
        step();
        expect_out("b2b.xor", 1'b1, 32'h0000FFFF, 1'b0, 1);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        step();
        expect_out("b2b.nor", 1'b1, 32'hFFFF0000, 1'b0, 0);
        step();
        expect_out("b2b.drain", 1'b0, 32'h0, 1'b0, 0);

        // Stall: three pushes with out_ready low
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 2'b00);
        step();
        drive(1'b1, 32'h00000001, 32'h00000002, 2'b01);
        step();
        expect_out("stall.e1", 1'b1, 32'hF000F000, 1'b0, 1);
        drive(1'b1, 32'hFFFFFFFF, 32'h0F0F0F0F, 2'b10);
        step();
        expect_out("stall.full", 1'b1, 32'hF000F000, 1'b0, 2);
        check("stall.in_ready", 32'(bus.in_ready), 32'd0);
        // Offer junk while full: must be refused
        drive(1'b1, 32'h12345678, 32'h0, 2'b01);
        step();
        expect_out("stall.hold", 1'b1, 32'hF000F000, 1'b0, 2);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        bus.out_ready = 1'b1;
        #1;
        check("stall.nopass", 32'(bus.in_ready), 32'd0);
        step();
        expect_out("stall.e2", 1'b1, 32'h00000003, 1'b0, 1);
        step();
        expect_out("stall.e3", 1'b1, 32'hF0F0F0F0, 1'b0, 0);
        step();
        expect_out("stall.drain", 1'b0, 32'h0, 1'b0, 0);

        // Simultaneous push and pop at count=1
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hFFFFFFFF, 32'h12345678, 2'b00);
        step();
        drive(1'b1, 32'h00FF0000, 32'h0000FF00, 2'b01);
        step();
        expect_out("pp.a", 1'b1, 32'h12345678, 1'b0, 1);
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0, 32'h0, 2'b11);
        step();
        expect_out("pp.b", 1'b1, 32'h00FFFF00, 1'b0, 1);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        step();
        expect_out("pp.c", 1'b1, 32'hFFFFFFFF, 1'b0, 0);
        step();
        expect_out("pp.drain", 1'b0, 32'h0, 1'b0, 0);

        // Reset mid-operation with count=2, out_valid=1
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h11111111, 32'h22222222, 2'b01);
        step();
        drive(1'b1, 32'h33333333, 32'h0, 2'b01);
        step();
        drive(1'b1, 32'h44444444, 32'h0, 2'b01);
        step();
        expect_out("mid.pre", 1'b1, 32'h33333333, 1'b0, 2);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        reset = 1'b1;
        #1;
        check("mid.valid", 32'(bus.out_valid), 32'd0);
        check("mid.count", 32'(bus.count), 32'd0);
        check("mid.out",   bus.out, 32'h0);
        check("mid.inrdy", 32'(bus.in_ready), 32'd0);
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("mid.post", 1'b0, 32'h0, 1'b0, 0);
        end

`ifdef LOGIC_OP_PIPE_PARITY_EN
        check("par.reset", 32'(bus.out_parity), 32'd0);
        drive(1'b1, 32'h00000001, 32'h00000002, 2'b01);
        step();
        drive(1'b1, 32'h00000007, 32'h00000000, 2'b01);
        step();
        expect_out("par.a", 1'b1, 32'h00000003, 1'b0, 1);
        check("par.a.p", 32'(bus.out_parity), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        step();
        expect_out("par.b", 1'b1, 32'h00000007, 1'b0, 0);
        check("par.b.p", 32'(bus.out_parity), 32'd1);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
